// File: rtl/exec_alu_ctrl_pkg.sv
// Shared definitions for the Y86-64 execute-stage ALU sequencer:
// instruction encodings, ALU function codes, CC bit positions and FSM states.
package exec_alu_ctrl_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam int CC_OF = 0;
    localparam int CC_ZF = 1;
    localparam int CC_SF = 2;

    localparam logic [2:0] CC_RESET = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_DONE   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    function automatic logic is_logic_op(input logic [3:0] ifun);
        return (ifun == F_AND) || (ifun == F_XOR);
    endfunction

endpackage

// File: rtl/exec_alu_ctrl_cond_eval.sv
// Combinational condition evaluator for cmovXX/jXX: maps (CC, ifun) to the
// branch/move outcome and flags ifun encodings that have no condition.
module cond_eval
    import exec_alu_ctrl_pkg::*;
(
    input  logic [2:0] i_cc,
    input  logic [3:0] i_ifun,
    output logic       o_cnd,
    output logic       o_valid_ifun
);

    logic w_lt;
    logic w_zf;

    assign w_lt = i_cc[CC_SF] ^ i_cc[CC_OF];
    assign w_zf = i_cc[CC_ZF];

    always_comb begin
        o_cnd        = 1'b0;
        o_valid_ifun = 1'b1;
        case (i_ifun)
            C_ALWAYS: o_cnd = 1'b1;
            C_LE:     o_cnd = w_lt | w_zf;
            C_L:      o_cnd = w_lt;
            C_E:      o_cnd = w_zf;
            C_NE:     o_cnd = ~w_zf;
            C_GE:     o_cnd = ~w_lt;
            C_G:      o_cnd = ~w_lt & ~w_zf;
            default:  o_valid_ifun = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_alu_ctrl.sv
// Execute-stage sequencer: latches one decoded bundle, steers the shared ALU
// for one cycle, owns the CC register and hands valE/Cnd downstream.
module exec_alu_ctrl
    import exec_alu_ctrl_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [N-1:0] in_valA,
    input  logic [N-1:0] in_valB,
    input  logic [N-1:0] in_valC,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_fun,
    input  logic [N-1:0] alu_out,
    input  logic [2:0]   alu_cf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_valE,
    output logic         out_cnd,
    output logic [3:0]   out_icode,
    output logic [2:0]   cc,
    output logic         halted,
    output logic         err
);

    localparam logic [N-1:0] L_PLUS8  = {{(N-4){1'b0}}, 4'h8};
    localparam logic [N-1:0] L_MINUS8 = {{(N-4){1'b1}}, 4'h8};

    state_t       r_state;
    state_t       w_state_next;

    logic [3:0]   r_icode;
    logic [3:0]   r_ifun;
    logic [N-1:0] r_valA;
    logic [N-1:0] r_valB;
    logic [N-1:0] r_valC;
    logic [N-1:0] r_valE;
    logic         r_cnd;
    logic [3:0]   r_out_icode;
    logic [2:0]   r_cc;
    logic         r_halted;
    logic         r_err;

    logic         w_accept;
    logic         w_cnd;
    logic         w_cond_valid;
    logic         w_is_cond;
    logic         w_valid_enc;
    logic         w_use_alu;
    logic         w_cc_we;
    logic [2:0]   w_cc_new;
    logic [N-1:0] w_aluA;
    logic [N-1:0] w_aluB;
    logic [1:0]   w_fun;

    // Condition is judged against CC as it stood before this instruction.
    cond_eval u_cond_eval (
        .i_cc         (r_cc),
        .i_ifun       (r_ifun),
        .o_cnd        (w_cnd),
        .o_valid_ifun (w_cond_valid)
    );

    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_is_cond   = (r_icode == I_CMOVXX) || (r_icode == I_JXX);
        w_valid_enc = 1'b1;
        if (r_icode > I_POPQ) begin
            w_valid_enc = 1'b0;
        end else if ((r_icode == I_OPQ) && (r_ifun > F_XOR)) begin
            w_valid_enc = 1'b0;
        end else if (w_is_cond && !w_cond_valid) begin
            w_valid_enc = 1'b0;
        end
        w_use_alu = w_valid_enc && !((r_icode == I_HALT) || (r_icode == I_NOP) ||
                                     (r_icode == I_JXX));
        w_cc_we   = w_valid_enc && (r_icode == I_OPQ);
        w_cc_new  = alu_cf;
        if (is_logic_op(r_ifun)) begin
            w_cc_new[CC_OF] = 1'b0;
        end
    end

    // Operand map: the ALU computes aluB op aluA, so alu_a carries aluB.
    always_comb begin
        w_aluA = '0;
        w_aluB = '0;
        w_fun  = ALU_ADD;
        if (w_valid_enc) begin
            case (r_icode)
                I_CMOVXX: w_aluA = r_valA;
                I_IRMOVQ: w_aluA = r_valC;
                I_RMMOVQ, I_MRMOVQ: begin
                    w_aluA = r_valC;
                    w_aluB = r_valB;
                end
                I_OPQ: begin
                    w_aluA = r_valA;
                    w_aluB = r_valB;
                    w_fun  = r_ifun[1:0];
                end
                I_CALL, I_PUSHQ: begin
                    w_aluA = L_MINUS8;
                    w_aluB = r_valB;
                end
                I_RET, I_POPQ: begin
                    w_aluA = L_PLUS8;
                    w_aluB = r_valB;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_next = S_EXEC;
            S_EXEC: w_state_next = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    if (r_halted)      w_state_next = S_HALTED;
                    else if (in_valid) w_state_next = S_EXEC;
                    else               w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_HALTED;
        endcase
    end

    // A halting result must not let a follow-on bundle slip in behind it.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_fun   = ALU_ADD;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_EXEC: begin
                alu_a   = w_aluB;
                alu_b   = w_aluA;
                alu_fun = w_fun;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready & ~r_halted;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_icode     <= '0;
            r_ifun      <= '0;
            r_valA      <= '0;
            r_valB      <= '0;
            r_valC      <= '0;
            r_valE      <= '0;
            r_cnd       <= 1'b0;
            r_out_icode <= '0;
            r_cc        <= CC_RESET;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_icode <= in_icode;
                r_ifun  <= in_ifun;
                r_valA  <= in_valA;
                r_valB  <= in_valB;
                r_valC  <= in_valC;
            end
            if (r_state == S_EXEC) begin
                r_valE      <= w_use_alu ? alu_out : '0;
                r_cnd       <= w_is_cond & w_valid_enc & w_cnd;
                r_out_icode <= r_icode;
                if (w_cc_we) begin
                    r_cc <= w_cc_new;
                end
                if (!w_valid_enc) begin
                    r_err <= 1'b1;
                end
                if (!w_valid_enc || (r_icode == I_HALT)) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign out_valE  = r_valE;
    assign out_cnd   = r_cnd;
    assign out_icode = r_out_icode;
    assign cc        = r_cc;
    assign halted    = r_halted;
    assign err       = r_err;

endmodule

// File: doc/exec_alu_ctrl.md
Name: exec_alu_ctrl

Overview:
- Execute-stage sequencer for the Y86-64 core's shared 64-bit ALU (add/sub/and/xor, flags OF/ZF/SF).
- Accepts one decoded instruction per valid/ready handshake and selects the ALU operands and function.
- Captures valE and owns the architectural condition-code register (CC), updating it only on OPq.
- Evaluates Cnd for cmovXX/jXX and presents the result downstream on a valid/ready handshake.

Parameters:
N, 64, datapath width; must match the ALU instance.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction bundle valid
in_ready  out  1  block can accept a bundle
in_icode  in  4  Y86 icode
in_ifun  in  4  Y86 ifun
in_valA  in  N  register operand A
in_valB  in  N  register operand B
in_valC  in  N  immediate/displacement
alu_a  out  N  ALU operand a
alu_b  out  N  ALU operand b
alu_fun  out  2  ALU control: 00 add, 01 sub (a-b), 10 and, 11 xor
alu_out  in  N  ALU result (combinational)
alu_cf  in  3  ALU flags: [0]=OF, [1]=ZF, [2]=SF
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_valE  out  N  execute result
out_cnd  out  1  condition outcome
out_icode  out  4  icode of the result
cc  out  3  CC register, same bit order as alu_cf
halted  out  1  halt or invalid instruction retired
err  out  1  sticky: invalid icode or ifun seen

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, out_valE=0, out_cnd=0, out_icode=0.
  - cc=3'b010 (ZF=1), halted=0, err=0.
  - alu_a, alu_b and alu_fun are driven 0.
  - Reset mid-operation discards the held bundle and any pending result.
- States:
  - IDLE: in_ready=1. On in_valid, latch icode/ifun/valA/valB/valC and go to EXEC.
  - EXEC: one cycle. alu_* are driven from the latched bundle. At the end of the cycle, capture alu_out into out_valE, update cc if needed, compute out_cnd, set out_valid=1 and go to DONE.
  - DONE: out_valid=1; outputs are held stable until out_ready.
    - out_ready with in_valid: accept the new bundle in the same cycle (in_ready=out_ready in DONE) and go to EXEC.
    - out_ready without in_valid: go to IDLE.
  - HALTED: terminal. in_ready=0; out_valid drops after the halting result is consumed. Only reset exits.
- Latency and throughput: a bundle accepted at edge T produces out_valid after edge T+1. Back-to-back throughput is one instruction per 2 cycles.
- Operand map (alu_a=aluB, alu_b=aluA; result = aluB op aluA):
  - 2 cmov: aluA=valA, aluB=0, add
  - 3 irmovq: aluA=valC, aluB=0, add
  - 4 rmmovq, 5 mrmovq: aluA=valC, aluB=valB, add
  - 6 OPq: aluA=valA, aluB=valB, fun=ifun[1:0]
  - 8 call, A pushq: aluA=-8, aluB=valB, add
  - 9 ret, B popq: aluA=+8, aluB=valB, add
  - 0 halt, 1 nop, 7 jXX: operands 0, add; valE=0
- CC rules:
  - CC is written from alu_cf only for icode 6 with ifun 0..3.
  - For and/xor, CC.OF is forced to 0.
  - No other icode touches CC.
- Cnd (icode 2 and 7 only; uses CC as it was before this instruction):
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&!ZF
  - Every other icode: out_cnd=0.
- Invalid encodings:
  - Covers icode >B, ifun>3 with icode 6, and ifun>6 with icode 2 or 7.
  - The result is still produced with out_cnd=0 and valE=0; CC is unchanged.
  - err is set, halted is set, and the FSM enters HALTED after the result is consumed.
- icode 0 (halt): the result is produced normally, then halted=1 and the FSM enters HALTED.
- Arithmetic: ±8 are sign-extended to N bits. All arithmetic wraps modulo 2^N; no saturation.

Decomposition:
- Shared package holds:
  - icode constants (I_HALT..I_POPQ)
  - ifun constants for OPq and conditions
  - ALU function codes (ALU_ADD/SUB/AND/XOR)
  - CC bit indices (CC_OF=0, CC_ZF=1, CC_SF=2)
  - the FSM state enum
- One natural sub-module: cond_eval, a combinational (cc, ifun) -> cnd, valid_ifun unit reused by fetch-side branch logic.

Test Plan:
1. Reset: hold rst_n=0 mid-EXEC -> out_valid=0, cc=010, in_ready=1, err=0 immediately (asynchronous).
2. OPq subq (icode 6, ifun 1), valA=5, valB=3 -> alu_fun=01, a=3, b=5; valE=0xFFFF_FFFF_FFFF_FFFE; cc SF=1, ZF=0, OF=0; out_valid one cycle after accept.
3. Add overflow: valA=valB=0x4000_0000_0000_0000 -> valE=0x8000_0000_0000_0000, OF=1, SF=1. A following xorq with the same operands -> valE=0, ZF=1, OF=0.
4. Branch after that xorq: jXX ifun 3 (e) -> cnd=1; ifun 4 -> cnd=0. cc is unchanged by the jumps.
5. Backpressure and streaming: hold out_ready=0 for 5 cycles -> out_valE stable, in_ready=0. Then out_ready=1 with in_valid=1 for pushq valB=0x100 -> next result valE=0xF8.
6. Invalid input icode=0xD -> out_valid with cnd=0; err=1 and halted=1; in_ready stays 0 until rst_n pulses.
